axi_stream_header_arbiter: RTL and testbench
============================================

Name: axi_stream_header_arbiter

Overview:
- Shares the header channel of the AXI-Stream header inserter among NUM_REQ header requesters.
- Round-robin grant of one header per packet. The grant locks until the inserter output completes the packet (tlast handshake on the monitored output), then re-arbitrates.
- Sits between requester header streams and the inserter s00 header port; taps the inserter m_axis handshake.

Parameters:
- DATA_WD, 32, header data width in bits.
- DATA_BYTE_WD, DATA_WD/8, tkeep width.
- NUM_REQ, 4, number of header requesters (2..16).
- CNT_WD, 16, width of the completed-packet counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_hdr_tvalid  in  NUM_REQ  per-requester header valid.
- s_hdr_tdata  in  NUM_REQ*DATA_WD  requester i occupies bits [i*DATA_WD +: DATA_WD].
- s_hdr_tkeep  in  NUM_REQ*DATA_BYTE_WD  packed per-requester tkeep.
- s_hdr_tready  out  NUM_REQ  one-hot-or-zero accept.
- m_hdr_tvalid  out  1  header to inserter valid.
- m_hdr_tdata  out  DATA_WD  registered header data.
- m_hdr_tkeep  out  DATA_BYTE_WD  registered header keep.
- m_hdr_tready  in  1  inserter header ready.
- mon_tvalid  in  1  tap of inserter m_axis_tvalid.
- mon_tready  in  1  tap of inserter m_axis_tready.
- mon_tlast  in  1  tap of inserter m_axis_tlast.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.
- busy  out  1  high in SEND or WAIT_EOP.
- pkt_cnt  out  CNT_WD  count of completed packets; wraps modulo 2^CNT_WD.

Behaviour:
- Reset (async, any time, including mid-packet):
  - state=IDLE; rr_ptr=0.
  - m_hdr_tvalid=0, m_hdr_tdata=0, m_hdr_tkeep=0.
  - s_hdr_tready=0, grant_id=0, busy=0, pkt_cnt=0.
  - No partial header is replayed after reset.
- States: IDLE, SEND, WAIT_EOP.
- IDLE:
  - Winner = first i with s_hdr_tvalid[i], searching from rr_ptr upward and wrapping at NUM_REQ-1 to 0.
  - s_hdr_tready[winner]=1 combinationally, in the same cycle only; the pop happens that cycle.
  - On the pop: latch tdata/tkeep into the holding register, grant_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, go to SEND.
  - No valid requester: stay in IDLE, s_hdr_tready=0.
- SEND:
  - m_hdr_tvalid=1; data/tkeep stable until accepted.
  - On m_hdr_tready: m_hdr_tvalid<=0 and go to WAIT_EOP.
  - s_hdr_tready=0 throughout.
- WAIT_EOP:
  - Completion is mon_tvalid & mon_tready & mon_tlast.
  - On completion: pkt_cnt<=pkt_cnt+1 and go to IDLE; a new grant becomes possible in the following cycle.
- Latency:
  - Header accept to m_hdr_tvalid = 1 cycle.
  - Minimum packet-to-packet grant spacing = 3 cycles (IDLE, SEND, WAIT_EOP each at least 1).
- Monitor events outside WAIT_EOP are ignored, including completion coinciding with the m_hdr_tready accept in SEND.
- Requester tvalid dropping before grant is allowed; it is simply not selected.
- Once m_hdr_tvalid rises it must not fall before m_hdr_tready.
- NUM_REQ=1 degenerates to a pass-through with packet lock; rr_ptr stays 0.

Optional Feature:
- Macro HDR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is neither implemented nor updated.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package axi_stream_hdr_pkg holds:
  - state enum (IDLE=0, SEND=1, WAIT_EOP=2, 2-bit encoding);
  - function clog2_min1 for grant index width.
- Sub-module hdr_rr_picker: combinational rotating-priority one-hot select.
  - Inputs: req vector, rr_ptr. Outputs: onehot, index, any.
  - Reused by the fixed-priority build with rr_ptr tied to 0.

Test Plan:
- Reset then idle: no tvalid for 10 cycles -> all outputs 0, busy=0, pkt_cnt=0.
- Single requester: req2 header 0xA5A5A5A5, keep 0xF, m_hdr_tready=1 -> s_hdr_tready=0b0100 for 1 cycle; m_hdr_tdata=0xA5A5A5A5 the next cycle; grant_id=2; busy until a mon tlast handshake; pkt_cnt=1.
- Fairness: all 4 requesters continuously valid, 8 packets -> grant order 0,1,2,3,0,1,2,3. With HDR_ARB_FIXED_PRIO_EN -> grant always 0.
- Backpressure: m_hdr_tready low 5 cycles in SEND -> m_hdr_tvalid/tdata held constant; no second s_hdr_tready pulse.
- Lock hold: mon_tvalid&mon_tready with tlast=0 for 20 beats and req1 valid -> no new grant until the tlast beat; req1 granted 1 cycle after.
- Async reset asserted in WAIT_EOP mid-packet -> state IDLE immediately, m_hdr_tvalid=0, pkt_cnt=0, rr_ptr=0; the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/axi_stream_hdr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_hdr_pkg
// Description : Shared types and helpers for the AXI-Stream header arbiter.
//               Holds the arbiter state encoding and the grant-index width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_stream_hdr_pkg;

    // Arbiter states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_EOP = 2'd2
    } hdr_state_e;

    // Index width that never collapses to zero bits (NUM_REQ=1 still
    // gets a 1-bit grant index).
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_stream_header_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module      : hdr_rr_picker
// Description : Combinational rotating-priority one-hot selector. The first
//               asserted request at or above rr_ptr wins; if none, the search
//               wraps to the lowest asserted request.
// Ports       : req    - request vector
//               rr_ptr - index with highest priority this cycle
//               onehot - one-hot winner (zero when no request)
//               index  - binary winner index (zero when no request)
//               any    - at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
module hdr_rr_picker
    import axi_stream_hdr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_WD  = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_WD-1:0]  rr_ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_WD-1:0]  index,
    output logic               any
);

    logic [NUM_REQ-1:0] w_masked;
    logic [NUM_REQ-1:0] w_sel;

    always_comb begin
        w_masked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_masked[i] = req[i] && (i >= int'(rr_ptr));
        end
        // Requests at/above the pointer take precedence; otherwise wrap.
        w_sel  = (|w_masked) ? w_masked : req;
        onehot = '0;
        index  = '0;
        // Descending scan so the lowest set bit of w_sel is the survivor.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                index     = IDX_WD'(i);
            end
        end
        any = |req;
    end

endmodule
`default_nettype wire

// File: rtl/axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_header_arbiter
// Description : Shares the header port of an AXI-Stream header inserter among
//               NUM_REQ requesters. One header is granted per packet; the
//               grant stays locked until the inserter output completes the
//               packet (tlast handshake on the monitor tap).
// Ports       : s_hdr_*  - packed requester header streams (in), tready (out)
//               m_hdr_*  - registered header stream to the inserter
//               mon_*    - tap of the inserter m_axis handshake and tlast
//               grant_id - index of the current or most recent grant
//               busy     - header pending or packet in flight
//               pkt_cnt  - completed-packet count, wraps
// Options     : HDR_ARB_FIXED_PRIO_EN - fixed priority (lowest index wins),
//               no round-robin pointer. Undefined: round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_header_arbiter
    import axi_stream_hdr_pkg::*;
#(
    parameter int   DATA_WD      = 32,
    parameter int   DATA_BYTE_WD = DATA_WD / 8,
    parameter int   NUM_REQ      = 4,
    parameter int   CNT_WD       = 16,
    localparam int  IDX_WD       = clog2_min1(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              s_hdr_tvalid,
    input  logic [NUM_REQ*DATA_WD-1:0]      s_hdr_tdata,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0] s_hdr_tkeep,
    output logic [NUM_REQ-1:0]              s_hdr_tready,
    output logic                            m_hdr_tvalid,
    output logic [DATA_WD-1:0]              m_hdr_tdata,
    output logic [DATA_BYTE_WD-1:0]         m_hdr_tkeep,
    input  logic                            m_hdr_tready,
    input  logic                            mon_tvalid,
    input  logic                            mon_tready,
    input  logic                            mon_tlast,
    output logic [IDX_WD-1:0]               grant_id,
    output logic                            busy,
    output logic [CNT_WD-1:0]               pkt_cnt
);

    hdr_state_e              r_state;
    logic                    r_m_valid;
    logic [DATA_WD-1:0]      r_m_data;
    logic [DATA_BYTE_WD-1:0] r_m_keep;
    logic [IDX_WD-1:0]       r_grant_id;
    logic                    r_busy;
    logic [CNT_WD-1:0]       r_pkt_cnt;

    logic [IDX_WD-1:0]       w_rr_ptr;
    logic [NUM_REQ-1:0]      w_onehot;
    logic [IDX_WD-1:0]       w_idx;
    logic                    w_any;
    logic                    w_pop;
    logic                    w_eop;
    logic [DATA_WD-1:0]      w_sel_data;
    logic [DATA_BYTE_WD-1:0] w_sel_keep;

    hdr_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_WD  (IDX_WD)
    ) u_picker (
        .req     (s_hdr_tvalid),
        .rr_ptr  (w_rr_ptr),
        .onehot  (w_onehot),
        .index   (w_idx),
        .any     (w_any)
    );

    assign w_pop = (r_state == IDLE) && w_any;
    assign w_eop = mon_tvalid && mon_tready && mon_tlast;

    // Ready is only offered in IDLE, and only to the winner.
    assign s_hdr_tready = (r_state == IDLE) ? w_onehot : '0;

    always_comb begin
        w_sel_data = '0;
        w_sel_keep = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_onehot[i]) begin
                w_sel_data = s_hdr_tdata[i*DATA_WD +: DATA_WD];
                w_sel_keep = s_hdr_tkeep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
            end
        end
    end

`ifdef HDR_ARB_FIXED_PRIO_EN
    assign w_rr_ptr = '0;
`else
    logic [IDX_WD-1:0] r_rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_pop) begin
            // Priority moves to the requester just after the winner.
            if (int'(w_idx) == NUM_REQ - 1) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_idx + 1'b1;
            end
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_keep   <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_m_data   <= w_sel_data;
                        r_m_keep   <= w_sel_keep;
                        r_grant_id <= w_idx;
                        r_m_valid  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    // Monitor activity here is ignored, even a coincident tlast.
                    if (m_hdr_tready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= WAIT_EOP;
                    end
                end
                WAIT_EOP: begin
                    if (w_eop) begin
                        r_pkt_cnt <= r_pkt_cnt + 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_m_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign m_hdr_tvalid = r_m_valid;
    assign m_hdr_tdata  = r_m_data;
    assign m_hdr_tkeep  = r_m_keep;
    assign grant_id     = r_grant_id;
    assign busy         = r_busy;
    assign pkt_cnt      = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_header_arbiter
// Description : Directed, table-driven bench for axi_stream_header_arbiter
//               (NUM_REQ=4, DATA_WD=32). Honours HDR_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_header_arbiter;

    localparam logic [127:0] c_lanes = {32'hD3D3_D3D3, 32'hA5A5_A5A5,
                                        32'hB1B1_B1B1, 32'hE0E0_E0E0};
    localparam logic [15:0]  c_keeps = 16'h8F31;

`ifdef HDR_ARB_FIXED_PRIO_EN
    localparam int c_fixed = 1;
    localparam int c_r7    = 1;   // {3,1} valid: lowest index wins
`else
    localparam int c_fixed = 0;
    localparam int c_r7    = 3;   // pointer sits at 3 after granting 2
`endif

    logic         clk;
    logic         rst;
    logic [3:0]   s_hdr_tvalid;
    logic [127:0] s_hdr_tdata;
    logic [15:0]  s_hdr_tkeep;
    logic [3:0]   s_hdr_tready;
    logic         m_hdr_tvalid;
    logic [31:0]  m_hdr_tdata;
    logic [3:0]   m_hdr_tkeep;
    logic         m_hdr_tready;
    logic         mon_tvalid;
    logic         mon_tready;
    logic         mon_tlast;
    logic [1:0]   grant_id;
    logic         busy;
    logic [15:0]  pkt_cnt;

    int n_checks;
    int n_errors;
    logic [15:0] exp_cnt;

    axi_stream_header_arbiter #(
        .DATA_WD (32),
        .NUM_REQ (4),
        .CNT_WD  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_hdr_tvalid (s_hdr_tvalid),
        .s_hdr_tdata  (s_hdr_tdata),
        .s_hdr_tkeep  (s_hdr_tkeep),
        .s_hdr_tready (s_hdr_tready),
        .m_hdr_tvalid (m_hdr_tvalid),
        .m_hdr_tdata  (m_hdr_tdata),
        .m_hdr_tkeep  (m_hdr_tkeep),
        .m_hdr_tready (m_hdr_tready),
        .mon_tvalid   (mon_tvalid),
        .mon_tready   (mon_tready),
        .mon_tlast    (mon_tlast),
        .grant_id     (grant_id),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic        mr;
        logic [2:0]  mon;     // {tvalid, tready, tlast}
        logic [3:0]  e_rdy;
        logic        e_mv;
        logic [1:0]  e_gid;
        logic        e_busy;
        logic [15:0] e_cnt;
        int          e_lane;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic [3:0] v, input logic mr,
                                input logic [2:0] mon, input logic [3:0] rdy,
                                input logic mv, input logic [1:0] gid,
                                input logic bsy, input logic [15:0] cnt,
                                input int lane);
        vec_t r;
        r.v = v; r.mr = mr; r.mon = mon; r.e_rdy = rdy; r.e_mv = mv;
        r.e_gid = gid; r.e_busy = bsy; r.e_cnt = cnt; r.e_lane = lane;
        return r;
    endfunction

    function automatic logic [31:0] lane_data(input int i);
        logic [127:0] l;
        l = c_lanes;
        return l[i*32 +: 32];
    endfunction

    function automatic logic [3:0] lane_keep(input int i);
        logic [15:0] k;
        k = c_keeps;
        return k[i*4 +: 4];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then let them settle.
    task automatic drive(input logic [3:0] v, input logic mr, input logic [2:0] mon);
        @(negedge clk);
        s_hdr_tvalid = v;
        m_hdr_tready = mr;
        {mon_tvalid, mon_tready, mon_tlast} = mon;
        #1;
    endtask

    task automatic fair_pkt(input int e, input int n);
        drive(4'b1111, 1'b1, 3'b000);
        chk($sformatf("fair%0d_rdy", n), 64'(s_hdr_tready), 64'(4'b0001 << e));
        chk($sformatf("fair%0d_cnt", n), 64'(pkt_cnt), 64'(exp_cnt));
        drive(4'b1111, 1'b1, 3'b000);
        chk($sformatf("fair%0d_mv", n), 64'(m_hdr_tvalid), 64'd1);
        chk($sformatf("fair%0d_gid", n), 64'(grant_id), 64'(e));
        chk($sformatf("fair%0d_data", n), 64'(m_hdr_tdata), 64'(lane_data(e)));
        drive(4'b1111, 1'b1, 3'b111);
        chk($sformatf("fair%0d_busy", n), 64'(busy), 64'd1);
        chk($sformatf("fair%0d_wrdy", n), 64'(s_hdr_tready), 64'd0);
        exp_cnt++;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        exp_cnt      = 16'd0;
        rst          = 1'b1;
        s_hdr_tvalid = '0;
        s_hdr_tdata  = c_lanes;
        s_hdr_tkeep  = c_keeps;
        m_hdr_tready = 1'b0;
        {mon_tvalid, mon_tready, mon_tlast} = 3'b000;

        // v, mr, mon, rdy, mv, gid, busy, cnt, lane
        tbl[0]  = mk(4'b0000, 0, 3'b000, 4'b0000, 0, 2'd0, 0, 16'd0, 0);
        tbl[1]  = mk(4'b0100, 1, 3'b000, 4'b0100, 0, 2'd0, 0, 16'd0, 0);
        tbl[2]  = mk(4'b0000, 1, 3'b000, 4'b0000, 1, 2'd2, 1, 16'd0, 2);
        tbl[3]  = mk(4'b0000, 0, 3'b110, 4'b0000, 0, 2'd2, 1, 16'd0, 0);
        tbl[4]  = mk(4'b0000, 0, 3'b111, 4'b0000, 0, 2'd2, 1, 16'd0, 0);
        tbl[5]  = mk(4'b0000, 0, 3'b000, 4'b0000, 0, 2'd2, 0, 16'd1, 0);
        tbl[6]  = mk(4'b0000, 0, 3'b111, 4'b0000, 0, 2'd2, 0, 16'd1, 0);
        tbl[7]  = mk(4'b1010, 0, 3'b000, 4'(4'b0001 << c_r7), 0, 2'd2, 0, 16'd1, 0);
        tbl[8]  = mk(4'b0000, 0, 3'b000, 4'b0000, 1, 2'(c_r7), 1, 16'd1, c_r7);
        tbl[9]  = mk(4'b0000, 1, 3'b111, 4'b0000, 1, 2'(c_r7), 1, 16'd1, c_r7);
        tbl[10] = mk(4'b0000, 0, 3'b000, 4'b0000, 0, 2'(c_r7), 1, 16'd1, 0);
        tbl[11] = mk(4'b0000, 0, 3'b111, 4'b0000, 0, 2'(c_r7), 1, 16'd1, 0);
        tbl[12] = mk(4'b0000, 0, 3'b000, 4'b0000, 0, 2'(c_r7), 0, 16'd2, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset then idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            drive(4'b0000, 1'b0, 3'b000);
            chk($sformatf("idle%0d_mv", i), 64'(m_hdr_tvalid), 64'd0);
            chk($sformatf("idle%0d_data", i), 64'(m_hdr_tdata), 64'd0);
            chk($sformatf("idle%0d_keep", i), 64'(m_hdr_tkeep), 64'd0);
            chk($sformatf("idle%0d_rdy", i), 64'(s_hdr_tready), 64'd0);
            chk($sformatf("idle%0d_busy", i), 64'(busy), 64'd0);
            chk($sformatf("idle%0d_gid", i), 64'(grant_id), 64'd0);
            chk($sformatf("idle%0d_cnt", i), 64'(pkt_cnt), 64'd0);
        end

        // Single requester, pointer wrap, ignored monitor events
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].mr, tbl[i].mon);
            chk($sformatf("row%0d_rdy", i), 64'(s_hdr_tready), 64'(tbl[i].e_rdy));
            chk($sformatf("row%0d_mv", i), 64'(m_hdr_tvalid), 64'(tbl[i].e_mv));
            chk($sformatf("row%0d_gid", i), 64'(grant_id), 64'(tbl[i].e_gid));
            chk($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("row%0d_cnt", i), 64'(pkt_cnt), 64'(tbl[i].e_cnt));
            if (tbl[i].e_mv) begin
                chk($sformatf("row%0d_data", i), 64'(m_hdr_tdata), 64'(lane_data(tbl[i].e_lane)));
                chk($sformatf("row%0d_keep", i), 64'(m_hdr_tkeep), 64'(lane_keep(tbl[i].e_lane)));
            end
        end
        exp_cnt = 16'd2;

        // Fairness: all requesters valid for 8 packets
        for (int n = 0; n < 8; n++) begin
            fair_pkt((c_fixed != 0) ? 0 : (n % 4), n);
        end

        // Backpressure: 5 cycles without m_hdr_tready in SEND
        drive(4'b0010, 1'b0, 3'b000);
        chk("bp_rdy", 64'(s_hdr_tready), 64'b0010);
        chk("bp_cnt", 64'(pkt_cnt), 64'(exp_cnt));
        for (int i = 0; i < 5; i++) begin
            drive(4'b0010, 1'b0, 3'b000);
            chk($sformatf("bp%0d_mv", i), 64'(m_hdr_tvalid), 64'd1);
            chk($sformatf("bp%0d_data", i), 64'(m_hdr_tdata), 64'(lane_data(1)));
            chk($sformatf("bp%0d_keep", i), 64'(m_hdr_tkeep), 64'(lane_keep(1)));
            chk($sformatf("bp%0d_rdy", i), 64'(s_hdr_tready), 64'd0);
        end
        drive(4'b0010, 1'b1, 3'b000);
        chk("bp_acc_mv", 64'(m_hdr_tvalid), 64'd1);
        chk("bp_acc_gid", 64'(grant_id), 64'd1);

        // Lock hold: 20 non-last beats, req1 waiting
        for (int i = 0; i < 20; i++) begin
            drive(4'b0010, 1'b0, 3'b110);
            chk($sformatf("lock%0d_rdy", i), 64'(s_hdr_tready), 64'd0);
            chk($sformatf("lock%0d_busy", i), 64'(busy), 64'd1);
            chk($sformatf("lock%0d_mv", i), 64'(m_hdr_tvalid), 64'd0);
        end
        drive(4'b0010, 1'b0, 3'b111);
        chk("lock_last_rdy", 64'(s_hdr_tready), 64'd0);
        exp_cnt++;
        drive(4'b0010, 1'b0, 3'b000);
        chk("lock_regrant_rdy", 64'(s_hdr_tready), 64'b0010);
        chk("lock_cnt", 64'(pkt_cnt), 64'(exp_cnt));
        drive(4'b0000, 1'b1, 3'b000);
        chk("lock_send_gid", 64'(grant_id), 64'd1);
        drive(4'b0000, 1'b0, 3'b110);
        chk("pre_rst_busy", 64'(busy), 64'd1);

        // Async reset mid-packet, away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mv", 64'(m_hdr_tvalid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cnt", 64'(pkt_cnt), 64'd0);
        chk("arst_gid", 64'(grant_id), 64'd0);
        chk("arst_data", 64'(m_hdr_tdata), 64'd0);
        chk("arst_rdy", 64'(s_hdr_tready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0110, 1'b1, 3'b000);
        chk("post_rst_rdy", 64'(s_hdr_tready), 64'b0010);
        drive(4'b0000, 1'b1, 3'b000);
        chk("post_rst_gid", 64'(grant_id), 64'd1);
        chk("post_rst_data", 64'(m_hdr_tdata), 64'(lane_data(1)));
        drive(4'b0000, 1'b0, 3'b111);
        drive(4'b0000, 1'b0, 3'b000);
        chk("post_rst_cnt", 64'(pkt_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
